ni_wr_arbiter: RTL and testbench
================================

// Module: ni_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one NI send path (swnet core write port) among
//  NUM_REQ core-side requesters. Grants are burst-locked: an owner keeps the port
//  for up to MAX_BURST accepted words, then ownership rotates. Sits between the
//  neuron cores and the NI instance; drives core_write_en/core_wdata/core_waddr.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  MSB_SLOT   5  RSIZE = 1<<(MSB_SLOT-1) = 16; half-packet width (addr or data)
//  MAX_BURST  4  max words accepted per grant before rotation (>=1)
// PORTS
//  clk            in   1               system clock, all logic on rising edge
//  reset          in   1               synchronous, active-high
//  req_valid      in   NUM_REQ         requester i has a word ready (level)
//  req_wdata      in   NUM_REQ*RSIZE   slice [i*RSIZE +: RSIZE] = data of req i
//  req_waddr      in   NUM_REQ*RSIZE   slice [i*RSIZE +: RSIZE] = dest router addr
//  req_grant      out  NUM_REQ         one-hot owner (registered); 0 when idle
//  req_ack        out  NUM_REQ         word of req i accepted this cycle
//  core_write_en  out  1               write strobe to NI send FIFO
//  core_wdata     out  RSIZE           muxed data of owner
//  core_waddr     out  RSIZE           muxed addr of owner
//  core_wfull     in   1               NI send FIFO full
//  busy           out  1               a grant is held (state GRANT)
// BEHAVIOUR
//  - Reset: state IDLE, req_grant=0, rr_ptr=0, burst_cnt=0; hence req_ack=0,
//    core_write_en=0, busy=0. Reset mid-burst drops grant on that edge, no word sent.
//  - Transfer: xfer = req_grant[k] & req_valid[k] & ~core_wfull (owner k).
//    core_write_en=xfer, req_ack=req_grant & {NUM_REQ{xfer}} (combinational).
//    core_wdata/core_waddr = owner slices while granted, else 0.
//  - Requester holds data stable while req_valid=1 and req_ack=0.
//  - Pick(s): first i in s, s+1, ... (mod NUM_REQ) with req_valid[i]=1.
//  - IDLE: if |req_valid, next cycle GRANT owner=Pick(rr_ptr), burst_cnt=0.
//    Grant is registered: first word moves 1 cycle after req_valid rises.
//  - GRANT, owner k, evaluated each cycle:
//    a) req_valid[k]=0: release; rr_ptr<=k+1; if others valid, owner<=Pick(k+1)
//       (no idle cycle), else IDLE.
//    b) xfer & burst_cnt==MAX_BURST-1: release, rr_ptr<=k+1; owner<=Pick(k+1)
//       over current req_valid (k itself regranted only if sole requester,
//       burst_cnt reset to 0); none valid -> IDLE.
//    c) xfer otherwise: burst_cnt<=burst_cnt+1, keep owner.
//    d) core_wfull=1: hold owner and burst_cnt; no ack; no timeout.
//  - burst_cnt width $clog2(MAX_BURST) (1 bit min); MAX_BURST=1 => per-word RR.
//  - rr_ptr wraps NUM_REQ-1 -> 0; never points outside 0..NUM_REQ-1.
//  - req_grant always one-hot or zero; at most one req_ack per cycle.
// TESTING
//  1 Reset: assert reset 2 cycles with all req_valid=1 -> req_grant=0,
//    core_write_en=0, busy=0 throughout; grant 4'b0001 the cycle after release.
//  2 Single req: req_valid=4'b0100, 6 words, wfull=0 -> grant 4'b0100 one cycle
//    later; 4 acks, 1-cycle regrant (cnt reset), 2 acks; waddr/wdata match order.
//  3 Contention: all 4 valid continuously, MAX_BURST=4 -> owner sequence
//    0,1,2,3,0 with exactly 4 consecutive acks each, no idle cycle between.
//  4 Backpressure: owner 1 mid-burst (cnt=2), wfull=1 for 5 cycles -> no ack,
//    no write_en, grant held; after release 2 more acks then rotate to 2.
//  5 Early drop: owner 0 drops req_valid after 1 word, req 3 valid -> grant moves
//    to 4'b1000 next cycle; rr_ptr=1 so later tie between 1 and 3 picks 1.
//  6 Reset mid-burst: reset while xfer on owner 2 -> that edge grant=0, the word
//    is not counted; bench checks no duplicate or lost word on scoreboard.

Source files
------------

// File: rtl/ni_wr_arbiter_if.sv
// Bundle of the requester-side and NI-side write signals shared by the arbiter.
// The master view is the environment (requesters plus NI FIFO); the slave view is the arbiter.
interface ni_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int RSIZE   = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*RSIZE-1:0] req_wdata;
    logic [NUM_REQ*RSIZE-1:0] req_waddr;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       req_ack;
    logic                     core_write_en;
    logic [RSIZE-1:0]         core_wdata;
    logic [RSIZE-1:0]         core_waddr;
    logic                     core_wfull;
    logic                     busy;

    // Handshake: a word of requester i moves in any cycle where req_valid[i],
    // req_grant[i] and !core_wfull all hold; req_ack[i] and core_write_en mark
    // that cycle. A requester keeps its slice stable until acked, but may drop
    // req_valid at any time to withdraw.
    modport master (
        output req_valid, req_wdata, req_waddr, core_wfull,
        input  req_grant, req_ack, core_write_en, core_wdata, core_waddr, busy
    );

    modport slave (
        input  req_valid, req_wdata, req_waddr, core_wfull,
        output req_grant, req_ack, core_write_en, core_wdata, core_waddr, busy
    );
endinterface

// File: rtl/ni_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one NI send port among NUM_REQ cores.
// The owner keeps the port for up to MAX_BURST accepted words, then ownership rotates.
module ni_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MSB_SLOT  = 5,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    ni_wr_arbiter_if.slave    bus,
    output logic              fsm_state
);
    localparam int RSIZE = 1 << (MSB_SLOT - 1);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               owner_valid;
    logic               xfer;
    logic [PTR_W-1:0]   pick_start;
    logic [PTR_W:0]     pick_res;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    // First valid requester scanning start, start+1, ... modulo NUM_REQ.
    function automatic logic [PTR_W:0] pick(input logic [PTR_W-1:0]   start,
                                            input logic [NUM_REQ-1:0] valid);
        logic             found;
        logic [PTR_W-1:0] idx;
        int               slot;
        found = 1'b0;
        idx   = start;
        for (int off = 0; off < NUM_REQ; off++) begin
            slot = (int'(start) + off) % NUM_REQ;
            if (!found && valid[slot]) begin
                found = 1'b1;
                idx   = PTR_W'(slot);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
    endfunction

    // Reset gates the strobe so a word presented in the reset cycle is never sent.
    assign owner_valid = bus.req_valid[owner_q];
    assign xfer        = (state_q == GRANT) && owner_valid && !bus.core_wfull && !reset;

    assign pick_start  = (state_q == GRANT) ? next_ptr(owner_q) : rr_ptr_q;
    assign pick_res    = pick(pick_start, bus.req_valid);
    assign pick_found  = pick_res[PTR_W];
    assign pick_idx    = pick_res[PTR_W-1:0];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // Release on withdrawal or on the last word of a burst; the next
                // owner is chosen in the same cycle so no idle gap appears.
                if (!owner_valid || (xfer && burst_cnt_q == LAST_CNT)) begin
                    rr_ptr_d    = next_ptr(owner_q);
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d == GRANT) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
        end
    end

    assign bus.req_grant     = grant_q;
    assign bus.req_ack       = grant_q & {NUM_REQ{xfer}};
    assign bus.core_write_en = xfer;
    assign bus.busy          = (state_q == GRANT);
    assign bus.core_wdata    = (state_q == GRANT) ? bus.req_wdata[owner_q*RSIZE +: RSIZE] : '0;
    assign bus.core_waddr    = (state_q == GRANT) ? bus.req_waddr[owner_q*RSIZE +: RSIZE] : '0;
    assign fsm_state         = state_q;

    assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_grant));
    assert property (@(posedge clk) disable iff (reset) int'(rr_ptr_q) < NUM_REQ);
endmodule

// File: tb/tb_ni_wr_arbiter.sv
// Directed and randomized bench for ni_wr_arbiter with a word-queue reference
// model of the round-robin, burst-locked ownership rules.
module tb_ni_wr_arbiter;
    localparam int N        = 4;
    localparam int MSB_SLOT = 5;
    localparam int RSIZE    = 16;
    localparam int MB       = 4;

    logic clk = 1'b0;
    logic reset;
    logic fsm_state;

    ni_wr_arbiter_if #(.NUM_REQ(N), .RSIZE(RSIZE)) bus ();

    ni_wr_arbiter #(.NUM_REQ(N), .MSB_SLOT(MSB_SLOT), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Pending words per requester, {addr, data}; head is what the requester shows.
    logic [31:0]  rq [N][$];
    logic [N-1:0] en;
    logic         wfull_drv;

    // Reference model: current owner (-1 = none), round-robin start, words in burst.
    int m_owner;
    int m_rr;
    int m_cnt;

    int checks;
    int passes;
    int fails;
    int loaded;
    int written;

    function automatic int m_pick(input int s, input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(s + off) % N]) return (s + off) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input int n);
        logic [31:0] w;
        repeat (n) begin
            w = $urandom;
            rq[i].push_back(w);
            loaded++;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, advance model at the rising edge.
    task automatic cycle(input logic rst);
        logic [N-1:0] v;
        logic [N-1:0] eg;
        logic [31:0]  head;
        logic [31:0]  ew;
        logic         exp_x;
        int           k;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && rq[i].size() > 0) v[i] = 1'b1;
            head = (rq[i].size() > 0) ? rq[i][0] : 32'h0;
            bus.req_waddr[i*RSIZE +: RSIZE] = head[31:16];
            bus.req_wdata[i*RSIZE +: RSIZE] = head[15:0];
        end
        reset          = rst;
        bus.req_valid  = v;
        bus.core_wfull = wfull_drv;
        #1;
        k     = m_owner;
        eg    = (k >= 0) ? (N'(1) << k) : '0;
        exp_x = (k >= 0) && v[k] && !wfull_drv && !rst;
        ew    = (k >= 0 && rq[k].size() > 0) ? rq[k][0] : 32'h0;
        check("grant", 32'(bus.req_grant), 32'(eg));
        check("ack", 32'(bus.req_ack), exp_x ? 32'(eg) : 32'h0);
        check("write_en", 32'(bus.core_write_en), 32'(exp_x));
        check("busy", 32'(bus.busy), 32'(k >= 0));
        check("fsm_state", 32'(fsm_state), 32'(k >= 0));
        check("waddr", 32'(bus.core_waddr), 32'(ew[31:16]));
        check("wdata", 32'(bus.core_wdata), 32'(ew[15:0]));
        if (bus.core_write_en === 1'b1) written++;
        @(posedge clk);
        if (exp_x) void'(rq[k].pop_front());
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_cnt   = 0;
        end else if (k < 0) begin
            m_owner = m_pick(m_rr, v);
            m_cnt   = 0;
        end else if (!v[k] || (exp_x && m_cnt == MB - 1)) begin
            m_rr    = (k + 1) % N;
            m_owner = m_pick(m_rr, v);
            m_cnt   = 0;
        end else if (exp_x) begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit done;
        en        = '1;
        wfull_drv = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (all_empty() && m_owner < 0) begin
                done = 1'b1;
                break;
            end
            cycle(1'b0);
        end
        check(tag, 32'(done), 32'h1);
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; loaded = 0; written = 0;
        m_owner = -1; m_rr = 0; m_cnt = 0;
        en = '0; wfull_drv = 1'b0;
        reset = 1'b1;
        bus.req_valid = '0; bus.req_wdata = '0; bus.req_waddr = '0; bus.core_wfull = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with every requester valid, then full four-way contention.
        for (int i = 0; i < N; i++) load(i, 8);
        en = '1;
        cycle(1'b1);
        cycle(1'b1);
        drain("t1_t3_drain");
        check("t3_words", 32'(written), 32'(loaded));

        // Single requester: six words, burst boundary regrants the same owner.
        load(2, 6);
        drain("t2_drain");
        check("t2_words", 32'(written), 32'(loaded));

        // Backpressure in the middle of owner 1's burst.
        load(1, 8);
        load(2, 3);
        en = 4'b0010;
        repeat (3) cycle(1'b0);
        en = 4'b0110;
        wfull_drv = 1'b1;
        repeat (5) cycle(1'b0);
        check("t4_grant_held", 32'(bus.req_grant), 32'h2);
        wfull_drv = 1'b0;
        drain("t4_drain");

        // Early drop by owner 0 while requester 3 waits.
        cycle(1'b1);
        load(0, 4);
        load(3, 2);
        en = 4'b1001;
        cycle(1'b0);
        cycle(1'b0);
        en = 4'b1000;
        cycle(1'b0);
        check("t5_grant_moves", 32'(bus.req_grant), 32'h8);
        load(1, 2);
        drain("t5_drain");

        // Reset while owner 2 is transferring; the word in flight must be resent.
        load(2, 6);
        en = 4'b0100;
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        check("t6_grant_dropped", 32'(bus.req_grant), 32'h0);
        drain("t6_drain");
        check("t6_words", 32'(written), 32'(loaded));

        // Randomized traffic, backpressure, withdrawals and occasional reset.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, N - 1), $urandom_range(1, 3));
            en        = N'($urandom);
            wfull_drv = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end
        drain("rand_drain");
        check("total_words", 32'(written), 32'(loaded));
        check("queues_empty", 32'(all_empty()), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
